// File: rtl/spatial_encoder_param.sv
// Spatial hypervector encoder: binds each channel's item-memory vector with its signed projection,
// votes per modality, and emits the 2-of-3 majority. Define SPATIAL_STALL_CNT_EN to add StallCnt_DO.

module spatial_encoder_param #(
    parameter  int HV_DIMENSION  = 2000,
    parameter  int CHANNEL_WIDTH = 8,
    parameter  int MOD1_CHANNELS = 32,
    parameter  int MOD2_CHANNELS = 77,
    parameter  int MOD3_CHANNELS = 105,
    localparam int N_CH          = MOD1_CHANNELS + MOD2_CHANNELS + MOD3_CHANNELS,
    localparam int AW            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                          Clk_CI,
    input  logic                          Reset_RBI,
    input  logic                          ValidIn_SI,
    output logic                          ReadyOut_SO,
    input  logic [CHANNEL_WIDTH*N_CH-1:0] ChannelsInput_DI,
    output logic                          MemReq_SO,
    output logic [AW-1:0]                 Addr_SO,
    input  logic                          MemValid_SI,
    input  logic [HV_DIMENSION-1:0]       IMData_DI,
    input  logic [HV_DIMENSION-1:0]       ProjPos_DI,
    input  logic [HV_DIMENSION-1:0]       ProjNeg_DI,
    output logic [HV_DIMENSION-1:0]       HypervectorOut_DO,
    output logic                          ValidOut_SO,
`ifdef SPATIAL_STALL_CNT_EN
    output logic [15:0]                   StallCnt_DO,
`endif
    input  logic                          ReadyIn_SI
);

    localparam int MAX_12 = (MOD1_CHANNELS > MOD2_CHANNELS) ? MOD1_CHANNELS : MOD2_CHANNELS;
    localparam int MAX_CH = (MAX_12 > MOD3_CHANNELS) ? MAX_12 : MOD3_CHANNELS;
    localparam int CNTW   = $clog2(MAX_CH + 1);

    localparam logic [AW-1:0] LAST_M1 = AW'(MOD1_CHANNELS - 1);
    localparam logic [AW-1:0] LAST_M2 = AW'(MOD1_CHANNELS + MOD2_CHANNELS - 1);
    localparam logic [AW-1:0] LAST_CH = AW'(N_CH - 1);

    localparam logic [CNTW:0] NUM_M1 = (CNTW + 1)'(MOD1_CHANNELS);
    localparam logic [CNTW:0] NUM_M2 = (CNTW + 1)'(MOD2_CHANNELS);
    localparam logic [CNTW:0] NUM_M3 = (CNTW + 1)'(MOD3_CHANNELS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENCODE = 2'd1,
        S_LATCH  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e                        r_state;
    state_e                        w_state_nxt;
    logic                          r_ready;
    logic                          r_mem_req;
    logic                          r_valid;
    logic                          w_ready_nxt;
    logic                          w_mem_req_nxt;
    logic                          w_valid_nxt;

    logic [CHANNEL_WIDTH*N_CH-1:0] r_features;
    logic [AW-1:0]                 r_ch_cnt;
    logic [1:0]                    r_mod_idx;
    logic [HV_DIMENSION-1:0]       r_mod_1;
    logic [HV_DIMENSION-1:0]       r_mod_2;
    logic [HV_DIMENSION-1:0]       r_hv_out;

    logic [N_CH-1:0]               w_sign;
    logic                          w_ch_sign;
    logic [HV_DIMENSION-1:0]       w_bound;
    logic [HV_DIMENSION-1:0]       w_vote;
    logic [AW-1:0]                 w_mod_last_addr;
    logic [CNTW:0]                 w_mod_num;
    logic                          w_mod_last;
    logic                          w_capture;
    logic                          w_accept;
    logic                          w_latch;
    logic                          w_final_latch;
    logic                          w_unused_feat;

    function automatic logic [HV_DIMENSION-1:0] majority3(
        input logic [HV_DIMENSION-1:0] a,
        input logic [HV_DIMENSION-1:0] b,
        input logic [HV_DIMENSION-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign w_capture     = (r_state == S_IDLE) && ValidIn_SI;
    assign w_accept      = (r_state == S_ENCODE) && MemValid_SI;
    assign w_latch       = (r_state == S_LATCH);
    assign w_final_latch = w_latch && (r_mod_idx == 2'd2);

    // Only the sign bit of each feature steers the binding; magnitudes are kept but unused.
    for (genvar c = 0; c < N_CH; c++) begin : g_sign
        assign w_sign[c] = r_features[CHANNEL_WIDTH*(N_CH-c)-1];
    end
    assign w_unused_feat = ^r_features;

    assign w_ch_sign = w_sign[r_ch_cnt];
    assign w_bound   = IMData_DI ^ (w_ch_sign ? ProjNeg_DI : ProjPos_DI);
    assign w_mod_last = (r_ch_cnt == w_mod_last_addr);

    // Boundary channel and channel count of the modality currently being encoded.
    always_comb begin
        w_mod_last_addr = LAST_CH;
        w_mod_num       = NUM_M3;
        case (r_mod_idx)
            2'd0: begin
                w_mod_last_addr = LAST_M1;
                w_mod_num       = NUM_M1;
            end
            2'd1: begin
                w_mod_last_addr = LAST_M2;
                w_mod_num       = NUM_M2;
            end
            default: begin
                w_mod_last_addr = LAST_CH;
                w_mod_num       = NUM_M3;
            end
        endcase
    end

    // Shared counter bank; a strict majority (ties lose) sets the modality bit.
    for (genvar i = 0; i < HV_DIMENSION; i++) begin : g_acc
        logic [CNTW-1:0] r_acc;

        // Per-bit accumulator: cleared on capture and after each modality vote.
        always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
            if (!Reset_RBI) begin
                r_acc <= '0;
            end else if (w_capture || w_latch) begin
                r_acc <= '0;
            end else if (w_accept) begin
                r_acc <= r_acc + CNTW'(w_bound[i]);
            end
        end

        assign w_vote[i] = ({r_acc, 1'b0} > w_mod_num);
    end

    // State register.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (ValidIn_SI) begin
                    w_state_nxt = S_ENCODE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ENCODE: begin
                if (MemValid_SI && w_mod_last) begin
                    w_state_nxt = S_LATCH;
                end else begin
                    w_state_nxt = S_ENCODE;
                end
            end
            S_LATCH: begin
                if (r_mod_idx == 2'd2) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_ENCODE;
                end
            end
            S_DONE: begin
                if (ReadyIn_SI) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the handshake outputs come straight from flops.
    always_comb begin
        w_ready_nxt   = 1'b0;
        w_mem_req_nxt = 1'b0;
        w_valid_nxt   = 1'b0;
        case (w_state_nxt)
            S_IDLE:   w_ready_nxt   = 1'b1;
            S_ENCODE: w_mem_req_nxt = 1'b1;
            S_LATCH: begin
                w_ready_nxt = 1'b0;
            end
            S_DONE:   w_valid_nxt   = 1'b1;
            default:  w_ready_nxt   = 1'b1;
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_ready   <= 1'b1;
            r_mem_req <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_ready   <= w_ready_nxt;
            r_mem_req <= w_mem_req_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    // Frame capture, channel walk and modality sequencing.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_features <= '0;
            r_ch_cnt   <= '0;
            r_mod_idx  <= 2'd0;
        end else if (w_capture) begin
            r_features <= ChannelsInput_DI;
            r_ch_cnt   <= '0;
            r_mod_idx  <= 2'd0;
        end else if (w_accept) begin
            if (r_ch_cnt != LAST_CH) begin
                r_ch_cnt <= r_ch_cnt + AW'(1);
            end
        end else if (w_latch && !w_final_latch) begin
            r_mod_idx <= r_mod_idx + 2'd1;
        end
    end

    // Modality votes and result; the third vote feeds the majority directly.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_mod_1  <= '0;
            r_mod_2  <= '0;
            r_hv_out <= '0;
        end else if (w_latch) begin
            if (r_mod_idx == 2'd0) begin
                r_mod_1 <= w_vote;
            end else if (r_mod_idx == 2'd1) begin
                r_mod_2 <= w_vote;
            end else begin
                r_hv_out <= majority3(r_mod_1, r_mod_2, w_vote);
            end
        end
    end

`ifdef SPATIAL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of memory-stall cycles within the current frame.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_stall_cnt <= 16'd0;
        end else if (w_capture) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state == S_ENCODE) && !MemValid_SI && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign StallCnt_DO = r_stall_cnt;
`endif

    assign ReadyOut_SO       = r_ready;
    assign MemReq_SO         = r_mem_req;
    assign ValidOut_SO       = r_valid;
    assign Addr_SO           = r_ch_cnt;
    assign HypervectorOut_DO = r_hv_out;

endmodule

// File: tb/tb_spatial_encoder_param.sv
// Randomized self-checking bench for spatial_encoder_param (HV=8, 4-bit features, modalities 3/2/4).
// Expected results come from a per-modality counting model over the bench's own frame tables.

module tb_spatial_encoder_param;

    localparam int HV   = 8;
    localparam int CW   = 4;
    localparam int M1   = 3;
    localparam int M2   = 2;
    localparam int M3   = 4;
    localparam int N_CH = M1 + M2 + M3;
    localparam int AW   = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             valid_in  = 1'b0;
    logic             mem_valid = 1'b0;
    logic             ready_in  = 1'b0;
    logic [CW*N_CH-1:0] ch_in   = '0;
    logic             ready_out;
    logic             mem_req;
    logic             valid_out;
    logic [AW-1:0]    addr;
    logic [HV-1:0]    im_d;
    logic [HV-1:0]    pp_d;
    logic [HV-1:0]    pn_d;
    logic [HV-1:0]    hv_out;
`ifdef SPATIAL_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    logic [CW-1:0] feat   [N_CH];
    logic [HV-1:0] mem_im [16];
    logic [HV-1:0] mem_pp [16];
    logic [HV-1:0] mem_pn [16];

    int n_checks = 0;
    int n_errors = 0;

    assign im_d = mem_im[addr];
    assign pp_d = mem_pp[addr];
    assign pn_d = mem_pn[addr];

    always #5 clk = ~clk;

    spatial_encoder_param #(
        .HV_DIMENSION  (HV),
        .CHANNEL_WIDTH (CW),
        .MOD1_CHANNELS (M1),
        .MOD2_CHANNELS (M2),
        .MOD3_CHANNELS (M3)
    ) dut (
        .Clk_CI            (clk),
        .Reset_RBI         (rst_n),
        .ValidIn_SI        (valid_in),
        .ReadyOut_SO       (ready_out),
        .ChannelsInput_DI  (ch_in),
        .MemReq_SO         (mem_req),
        .Addr_SO           (addr),
        .MemValid_SI       (mem_valid),
        .IMData_DI         (im_d),
        .ProjPos_DI        (pp_d),
        .ProjNeg_DI        (pn_d),
        .HypervectorOut_DO (hv_out),
        .ValidOut_SO       (valid_out),
`ifdef SPATIAL_STALL_CNT_EN
        .StallCnt_DO       (stall_cnt),
`endif
        .ReadyIn_SI        (ready_in)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count bound ones per bit per modality, strict majority vote, then 2-of-3 across modalities.
    function automatic logic [HV-1:0] ref_model();
        int            sizes [3];
        logic [HV-1:0] mreg  [3];
        logic [HV-1:0] bound;
        logic [HV-1:0] res;
        int            base;
        int            cnt;
        int            votes;
        sizes[0] = M1;
        sizes[1] = M2;
        sizes[2] = M3;
        base = 0;
        for (int m = 0; m < 3; m++) begin
            for (int b = 0; b < HV; b++) begin
                cnt = 0;
                for (int c = base; c < base + sizes[m]; c++) begin
                    bound = mem_im[c] ^ (feat[c][CW-1] ? mem_pn[c] : mem_pp[c]);
                    cnt += int'(bound[b]);
                end
                mreg[m][b] = (2 * cnt > sizes[m]);
            end
            base += sizes[m];
        end
        for (int b = 0; b < HV; b++) begin
            votes = int'(mreg[0][b]) + int'(mreg[1][b]) + int'(mreg[2][b]);
            res[b] = (votes >= 2);
        end
        return res;
    endfunction

    task automatic pack_features();
        for (int c = 0; c < N_CH; c++) begin
            ch_in[CW*(N_CH-c)-1 -: CW] = feat[c];
        end
    endtask

    task automatic random_frame();
        for (int c = 0; c < N_CH; c++) begin
            feat[c]   = CW'($urandom);
            mem_im[c] = HV'($urandom);
            mem_pp[c] = HV'($urandom);
            mem_pn[c] = HV'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 32'(ready_out), 32'd1);
        check_val({tag, "_valid"}, 32'(valid_out), 32'd0);
        check_val({tag, "_memreq"}, 32'(mem_req), 32'd0);
        check_val({tag, "_addr"}, 32'(addr), 32'd0);
        check_val({tag, "_hv"}, 32'(hv_out), 32'd0);
`ifdef SPATIAL_STALL_CNT_EN
        check_val({tag, "_stallcnt"}, 32'(stall_cnt), 32'd0);
`endif
    endtask

    // stall_mode: 0 none, 1 five-cycle burst after first channel, 2 random. abort_at >= 0 resets mid-frame.
    task automatic run_frame(input int stall_mode, input int hold_cycles, input int abort_at);
        logic [HV-1:0] exp_hv;
        int            edges;
        int            k;
        int            stalls;
        int            stall_run;
        bit            done;
        exp_hv = ref_model();
        @(negedge clk);
        check_val("ready_idle", 32'(ready_out), 32'd1);
        pack_features();
        valid_in = 1'b1;
        @(posedge clk);
        edges     = 0;
        k         = 0;
        stalls    = 0;
        stall_run = 0;
        done      = 1'b0;
        while (edges < 300) begin
            @(negedge clk);
            valid_in = 1'b0;
            if (valid_out) begin
                done = 1'b1;
                break;
            end
            if (abort_at >= 0 && mem_req && k == abort_at) begin
                rst_n     = 1'b0;
                mem_valid = 1'b0;
                #1;
                check_reset_outputs("midreset");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            mem_valid = 1'b1;
            if (stall_mode == 1 && k == 1 && stall_run < 5) begin
                mem_valid = 1'b0;
                stall_run++;
            end else if (stall_mode == 2 && $urandom_range(0, 3) == 0) begin
                mem_valid = 1'b0;
            end
            if (mem_req) begin
                if (mem_valid) begin
                    check_val("addr_order", 32'(addr), 32'(k));
                    k++;
                end else begin
                    stalls++;
                end
            end
            @(posedge clk);
            edges++;
        end
        mem_valid = 1'b0;
        check_val("timeout", 32'(done), 32'd1);
        if (!done) return;
        check_val("channels", 32'(k), 32'(N_CH));
        check_val("latency", 32'(edges), 32'(N_CH + 3 + stalls));
        check_val("result", 32'(hv_out), 32'(exp_hv));
        check_val("ready_done", 32'(ready_out), 32'd0);
        check_val("memreq_done", 32'(mem_req), 32'd0);
`ifdef SPATIAL_STALL_CNT_EN
        check_val("stallcnt", 32'(stall_cnt), 32'(stalls));
`endif
        for (int h = 0; h < hold_cycles; h++) begin
            valid_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_val("hold_valid", 32'(valid_out), 32'd1);
            check_val("hold_result", 32'(hv_out), 32'(exp_hv));
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        check_val("release_valid", 32'(valid_out), 32'd0);
        check_val("release_ready", 32'(ready_out), 32'd1);
        check_val("idle_hold_result", 32'(hv_out), 32'(exp_hv));
        @(negedge clk);
        check_val("idle_stays", 32'(mem_req), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_im[i] = '0;
            mem_pp[i] = '0;
            mem_pn[i] = '0;
        end
        for (int c = 0; c < N_CH; c++) begin
            feat[c] = '0;
        end
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // All-positive features select ProjPos everywhere.
        for (int c = 0; c < N_CH; c++) begin
            feat[c]   = CW'($urandom_range(0, 7));
            mem_im[c] = 8'h00;
            mem_pp[c] = 8'hA5;
            mem_pn[c] = HV'($urandom);
        end
        run_frame(0, 0, -1);

        // Modality 2 splits evenly, so it must vote zero.
        for (int c = 0; c < N_CH; c++) begin
            feat[c]   = CW'($urandom_range(0, 7));
            mem_im[c] = 8'h00;
            mem_pp[c] = 8'h0F;
            mem_pn[c] = HV'($urandom);
        end
        mem_pp[3] = 8'hFF;
        mem_pp[4] = 8'h00;
        run_frame(0, 2, -1);

        // Stall burst inside modality 1, then the same frame without stalls.
        random_frame();
        run_frame(1, 0, -1);
        run_frame(0, 0, -1);

        // Reset during channel 6, then a fresh frame.
        random_frame();
        run_frame(2, 0, 6);
        random_frame();
        run_frame(0, 1, -1);

        // Long downstream back-pressure with ValidIn pulses.
        random_frame();
        run_frame(0, 10, -1);

        for (int n = 0; n < 8; n++) begin
            random_frame();
            run_frame(2, $urandom_range(0, 3), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spatial_encoder_param.md
SPATIAL_ENCODER_PARAM -- requirements
Module: spatial_encoder_param

Interface
REQ-001 Parameters SHALL be: HV_DIMENSION (default 2000), hypervector width; CHANNEL_WIDTH (default 8), signed feature width; MOD1_CHANNELS (default 32), MOD2_CHANNELS (default 77), MOD3_CHANNELS (default 105), channel counts of modalities 1/2/3, each >=1; N_CH = sum of the three; AW = ceilLog2(N_CH).
REQ-002 Clk_CI  in  1  single clock, rising edge.
REQ-003 Reset_RBI  in  1  asynchronous, active-low reset.
REQ-004 ValidIn_SI  in  1  input frame valid; ReadyOut_SO  out  1  ready to accept a frame.
REQ-005 ChannelsInput_DI  in  CHANNEL_WIDTH*N_CH  features, channel 0 in MSBs.
REQ-006 MemReq_SO  out  1  memory read request; Addr_SO  out  AW  channel index.
REQ-007 MemValid_SI  in  1  memory data valid for current Addr_SO.
REQ-008 IMData_DI, ProjPos_DI, ProjNeg_DI  in  HV_DIMENSION each  item-memory and positive/negative projection vectors.
REQ-009 HypervectorOut_DO  out  HV_DIMENSION  encoded result; ValidOut_SO  out  1  result valid; ReadyIn_SI  in  1  downstream accepts result.

Function
REQ-010 States SHALL be IDLE, ENCODE, LATCH, DONE.
REQ-011 IDLE: ReadyOut_SO=1; on ValidIn_SI=1 capture all features into input register, clear channel counter and accumulators, go ENCODE.
REQ-012 ENCODE: MemReq_SO=1, Addr_SO=channel counter; only cycles with MemValid_SI=1 accumulate and advance counter; MemValid_SI=0 stalls with all state held.
REQ-013 Bound vector SHALL be IMData_DI XOR (feature MSB=1 ? ProjNeg_DI : ProjPos_DI) of addressed channel.
REQ-014 One shared counter bank: HV_DIMENSION counters, width ceilLog2(max modality channels + 1); each counter increments where bound bit is 1; no overflow possible by sizing.
REQ-015 Channels SHALL be processed in order 0..N_CH-1; modality 1 = first MOD1_CHANNELS, then modality 2, then modality 3.
REQ-016 After accumulating the last channel of a modality, go LATCH for exactly one cycle (MemReq_SO=0): modality register bit = 1 iff 2*count > modality channel count (ties give 0); clear counters; return to ENCODE, or after modality 3 go DONE.
REQ-017 On leaving the third LATCH, HypervectorOut_DO SHALL load the bitwise 2-of-3 majority of the three modality registers.
REQ-018 DONE: ValidOut_SO=1, HypervectorOut_DO stable; on ReadyIn_SI=1 go IDLE; ValidIn_SI ignored outside IDLE.
REQ-019 Latency with MemValid_SI held 1: ValidOut_SO high N_CH+3 rising edges after capture edge.
REQ-020 HypervectorOut_DO SHALL hold its value through IDLE until next result loads.
REQ-021 Channel counter wraps to 0 only via clear in IDLE; never exceeds N_CH-1.

Reset
REQ-022 Reset_RBI=0 SHALL immediately force IDLE, clear input register, counters, modality registers, HypervectorOut_DO to 0; ReadyOut_SO=1, ValidOut_SO=0, MemReq_SO=0, Addr_SO=0.
REQ-023 Reset mid-ENCODE/LATCH SHALL discard the frame; first frame after release processes normally.

Configuration
REQ-024 With SPATIAL_STALL_CNT_EN defined, output StallCnt_DO (16 bits) SHALL count ENCODE cycles with MemValid_SI=0, cleared on capture, saturating at 65535, reset 0; without it the port and counter SHALL not exist and behaviour is otherwise identical.

Verification (HV_DIMENSION=8, CHANNEL_WIDTH=4, MOD1/2/3=3/2/4)
REQ-025 All features positive, IMData=0x00, ProjPos=0xA5, MemValid=1 -> HypervectorOut=0xA5, ValidOut high 12 edges after capture.
REQ-026 Modality 2 ties (channel 0 bound 0xFF, channel 1 bound 0x00), others bound 0x0F -> modality 2 register 0x00, output 0x0F.
REQ-027 MemValid low 5 cycles mid-modality 1 -> output unchanged vs. no-stall run, ValidOut delayed 5 cycles, StallCnt_DO=5 when macro defined.
REQ-028 Reset_RBI pulsed low during channel 6 -> outputs at reset values same cycle; next frame produces its correct result.
REQ-029 ReadyIn_SI low 10 cycles in DONE -> ValidOut and output held 10 cycles; ValidIn pulses ignored; IDLE after ReadyIn high.
